stop_watch_ctrl: RTL and testbench

Button-driven control FSM for the three-digit stopwatch. It debounces the start/stop and lap/clear push-buttons and sequences the cascade counter through its `go`/`clr` inputs. It also selects what the hex display multiplexer shows: live digits, or digits frozen at a lap capture. It sits between the board buttons, the stopwatch counter and the display mux, replacing the direct button-to-counter wiring.

---
 rtl/stop_watch_ctrl.sv | 157 +++++++++++++++
 tb/tb_stop_watch_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/stop_watch_ctrl.sv
// ----------------------------------------------------------------------------
// stop_watch_ctrl : debounces start/stop and lap/clear buttons, sequences the
//                   stopwatch counter and selects live or lap-frozen digits.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module stop_watch_ctrl #(
  parameter int DB_TICKS = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  output logic       go,
  output logic       clr,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [3:0] dp_out
);

  localparam int CW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DB_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAP  = 2'd2,
    S_STOP = 2'd3
  } state_e;

  // Bit 0 = start/stop, bit 1 = lap/clear
  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  logic [1:0]    db_q;
  logic [1:0]    db_prev_q;
  logic [CW-1:0] cnt_q [2];
  logic [1:0]    w_press;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
    end else begin
      sync1_q   <= {btn_lap, btn_ss};
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int b = 0; b < 2; b++) begin
        if (sync2_q[b] == db_q[b]) begin
          cnt_q[b] <= '0;
        end else if (cnt_q[b] == C_CNT_MAX) begin
          db_q[b]  <= sync2_q[b];
          cnt_q[b] <= '0;
        end else begin
          cnt_q[b] <= cnt_q[b] + CW'(1);
        end
      end
    end
  end

  assign w_press = db_q & ~db_prev_q;

  state_e     state_q, state_d;
  logic       w_cap;
  logic       w_clr_lap;
  logic [3:0] lap2_q, lap1_q, lap0_q;
  logic [3:0] lap_cnt_q;

  // Start/stop has priority; a simultaneous lap press is dropped
  always_comb begin
    state_d   = state_q;
    w_cap     = 1'b0;
    w_clr_lap = 1'b0;
    case (state_q)
      S_IDLE: if (w_press[0]) state_d = S_RUN;
      S_RUN: begin
        if (w_press[0]) begin
          state_d = S_STOP;
        end else if (w_press[1]) begin
          state_d = S_LAP;
          w_cap   = 1'b1;
        end
      end
      S_LAP: begin
        if (w_press[0])      state_d = S_STOP;
        else if (w_press[1]) state_d = S_RUN;
      end
      S_STOP: begin
        if (w_press[0]) begin
          state_d = S_RUN;
        end else if (w_press[1]) begin
          state_d   = S_IDLE;
          w_clr_lap = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lap2_q    <= '0;
      lap1_q    <= '0;
      lap0_q    <= '0;
      lap_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_cap) begin
        lap2_q    <= d2;
        lap1_q    <= d1;
        lap0_q    <= d0;
        lap_cnt_q <= (lap_cnt_q == 4'd9) ? 4'd0 : lap_cnt_q + 4'd1;
      end else if (w_clr_lap) begin
        lap2_q    <= '0;
        lap1_q    <= '0;
        lap0_q    <= '0;
        lap_cnt_q <= '0;
      end
    end
  end

  assign hex3 = lap_cnt_q;

  always_comb begin
    go     = 1'b0;
    clr    = 1'b0;
    hex2   = d2;
    hex1   = d1;
    hex0   = d0;
    dp_out = 4'b1101;
    case (state_q)
      S_IDLE: clr = 1'b1;
      S_RUN:  go  = 1'b1;
      S_LAP: begin
        go     = 1'b1;
        hex2   = lap2_q;
        hex1   = lap1_q;
        hex0   = lap0_q;
        dp_out = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_stop_watch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_stop_watch_ctrl : directed vector bench for stop_watch_ctrl (DB_TICKS=4)
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_stop_watch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_ss = 1'b0;
  logic       btn_lap = 1'b0;
  logic [3:0] d2 = '0, d1 = '0, d0 = '0;
  logic       go, clr;
  logic [3:0] hex3, hex2, hex1, hex0, dp_out;

  int checks = 0;
  int errors = 0;

  stop_watch_ctrl #(.DB_TICKS(4)) dut (
    .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lap(btn_lap),
    .d2(d2), .d1(d1), .d0(d0),
    .go(go), .clr(clr),
    .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0), .dp_out(dp_out)
  );

  always #5 clk = ~clk;

  // {go, clr, hex3, hex2, hex1, hex0, dp_out}
  function automatic logic [21:0] pack(input logic g, input logic c, input logic [3:0] h3,
                                       input logic [3:0] h2, input logic [3:0] h1,
                                       input logic [3:0] h0, input logic [3:0] dp);
    return {g, c, h3, h2, h1, h0, dp};
  endfunction

  task automatic chk(input string name, input logic [21:0] act, input logic [21:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic ss, input logic lap);
    btn_ss  = ss;
    btn_lap = lap;
    repeat (8) step();
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    repeat (8) step();
  endtask

  function automatic logic [21:0] outs();
    return pack(go, clr, hex3, hex2, hex1, hex0, dp_out);
  endfunction

  typedef struct {
    string      name;
    logic       ss;
    logic       lap;
    logic [11:0] d_press;
    logic [11:0] d_chk;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    // Sequence starting from RUN with lap count 0
    vecs[0] = '{"lap_capture", 1'b0, 1'b1, 12'h345, 12'h999, pack(1, 0, 4'd1, 4'd3, 4'd4, 4'd5, 4'b1111)};
    vecs[1] = '{"lap_release", 1'b0, 1'b1, 12'h111, 12'h222, pack(1, 0, 4'd1, 4'd2, 4'd2, 4'd2, 4'b1101)};
    vecs[2] = '{"run_stop",    1'b1, 1'b0, 12'h000, 12'h123, pack(0, 0, 4'd1, 4'd1, 4'd2, 4'd3, 4'b1101)};
    vecs[3] = '{"stop_clear",  1'b0, 1'b1, 12'h000, 12'h456, pack(0, 1, 4'd0, 4'd4, 4'd5, 4'd6, 4'b1101)};
    vecs[4] = '{"idle_lap",    1'b0, 1'b1, 12'h000, 12'h000, pack(0, 1, 4'd0, 4'd0, 4'd0, 4'd0, 4'b1101)};
    vecs[5] = '{"idle_start",  1'b1, 1'b0, 12'h000, 12'h789, pack(1, 0, 4'd0, 4'd7, 4'd8, 4'd9, 4'b1101)};
    vecs[6] = '{"both_press",  1'b1, 1'b1, 12'h000, 12'h321, pack(0, 0, 4'd0, 4'd3, 4'd2, 4'd1, 4'b1101)};
    vecs[7] = '{"stop_start",  1'b1, 1'b0, 12'h000, 12'h000, pack(1, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b1101)};

    // Reset state with live pass-through
    d2 = 4'd7; d1 = 4'd8; d0 = 4'd9;
    repeat (2) step();
    reset = 1'b0;
    step();
    chk("reset_state", outs(), pack(0, 1, 4'd0, 4'd7, 4'd8, 4'd9, 4'b1101));

    // Bounce rejection: 2 high / 2 low never reaches 4 stable cycles
    d2 = 4'd0; d1 = 4'd0; d0 = 4'd0;
    for (int i = 0; i < 5; i++) begin
      btn_ss = 1'b1; repeat (2) step();
      btn_ss = 1'b0; repeat (2) step();
    end
    repeat (12) step();
    chk("bounce_reject", outs(), pack(0, 1, 4'd0, 4'd0, 4'd0, 4'd0, 4'b1101));

    // Start latency: go/clr change exactly at edge 7
    btn_ss = 1'b1;
    repeat (6) step();
    chk("start_edge6", outs(), pack(0, 1, 4'd0, 4'd0, 4'd0, 4'd0, 4'b1101));
    step();
    chk("start_edge7", outs(), pack(1, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b1101));
    repeat (3) step();
    btn_ss = 1'b0;
    repeat (12) step();
    chk("start_release", outs(), pack(1, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b1101));

    for (int v = 0; v < 8; v++) begin
      {d2, d1, d0} = vecs[v].d_press;
      press(vecs[v].ss, vecs[v].lap);
      {d2, d1, d0} = vecs[v].d_chk;
      #1;
      chk(vecs[v].name, outs(), vecs[v].exp);
    end

    // Ten lap captures: counter 1..9 then wraps to 0
    for (int i = 0; i < 10; i++) begin
      d2 = 4'(i); d1 = 4'(i); d0 = 4'(9 - i);
      press(1'b0, 1'b1);
      chk($sformatf("wrap_cap%0d", i), outs(),
          pack(1, 0, 4'((i + 1) % 10), 4'(i), 4'(i), 4'(9 - i), 4'b1111));
      press(1'b0, 1'b1);
      chk($sformatf("wrap_rel%0d", i), outs(),
          pack(1, 0, 4'((i + 1) % 10), 4'(i), 4'(i), 4'(9 - i), 4'b1101));
    end

    // Reset while lap is mid-debounce discards the pending press
    d2 = 4'd5; d1 = 4'd5; d0 = 4'd5;
    btn_lap = 1'b1;
    repeat (4) step();
    reset   = 1'b1;
    btn_lap = 1'b0;
    step();
    reset = 1'b0;
    chk("mid_reset", outs(), pack(0, 1, 4'd0, 4'd5, 4'd5, 4'd5, 4'b1101));
    repeat (12) step();
    chk("mid_reset_settle", outs(), pack(0, 1, 4'd0, 4'd5, 4'd5, 4'd5, 4'b1101));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
